// File: rtl/pe_conv1d.sv
// pe_conv1d: single processing element for a 1-D strided convolution.
//
// Weights and activations are streamed into local storage while idle. A start
// pulse latches the geometry (K taps, A activations, stride S, ReLU) and the
// element then produces N = floor((A-K)/S)+1 outputs. Each output takes one MAC
// cycle per tap, and then waits on a valid/ready handshake.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-low reset
//   filter_input / load_enable_weight          weight load stream
//   activation_input / load_enable_activation  activation load stream
//   kernel_len, act_len, stride, relu_en       run configuration (sampled on start)
//   start                      begin a run (honoured only in IDLE)
//   out_ready                  consumer accepts processingelement_out
//   processingelement_out, out_valid           result word and its valid flag
//   busy                       high whenever not IDLE
//   load_done                  pulse after the last word of a weight/activation block
//   compute_done               pulse in the single DONE cycle
//   cfg_error                  pulse after a rejected start
module pe_conv1d #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int MAX_KERNEL = 8,
  parameter int MAX_ACT    = 64,
  parameter int FRAC_BITS  = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_WIDTH-1:0]             filter_input,
  input  logic [DATA_WIDTH-1:0]             activation_input,
  input  logic                              load_enable_weight,
  input  logic                              load_enable_activation,
  input  logic [$clog2(MAX_KERNEL+1)-1:0]   kernel_len,
  input  logic [$clog2(MAX_ACT+1)-1:0]      act_len,
  input  logic [2:0]                        stride,
  input  logic                              relu_en,
  input  logic                              start,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             processingelement_out,
  output logic                              out_valid,
  output logic                              busy,
  output logic                              load_done,
  output logic                              compute_done,
  output logic                              cfg_error
);

  localparam int KW  = $clog2(MAX_KERNEL+1);
  localparam int AW  = $clog2(MAX_ACT+1);
  localparam int KIW = (MAX_KERNEL > 1) ? $clog2(MAX_KERNEL) : 1;
  localparam int AIW = (MAX_ACT > 1) ? $clog2(MAX_ACT) : 1;
  localparam int CW  = ((KW > AW) ? KW : AW) + 1;
  localparam int BW  = AW + 2;

  // Saturation bounds of the signed DATA_WIDTH range, held at accumulator width.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, MAC, OUTPUT, DONE} state_t;

  typedef struct packed {
    logic [KW-1:0] k;
    logic [AW-1:0] a;
    logic [2:0]    s;
    logic          relu;
  } cfg_t;

  state_t state, state_nxt;
  cfg_t   cfg;

  logic [KW-1:0] wptr, kcnt;
  logic [AW-1:0] aptr;
  // base = o*S, the first activation of the current window; stepping it by S
  // per output avoids a multiplier and doubles as the output index.
  logic [AW-1:0] base;
  logic [KW:0]   wptr_nx;
  logic [AW:0]   aptr_nx;

  logic signed [DATA_WIDTH-1:0]   w_mem [MAX_KERNEL];
  logic signed [DATA_WIDTH-1:0]   a_mem [MAX_ACT];
  logic signed [DATA_WIDTH-1:0]   w_rd, a_rd;
  logic [AIW-1:0]                 a_addr;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext, acc, acc_sum, acc_sh;
  logic [DATA_WIDTH-1:0]          res;
  logic                           cfg_ok, last_k, last_out, hs, load_ok;

  assign busy    = (state != IDLE);
  assign hs      = out_valid && out_ready;
  assign wptr_nx = {1'b0, wptr} + (KW+1)'(1);
  assign aptr_nx = {1'b0, aptr} + (AW+1)'(1);
  assign load_ok = reset && (state == IDLE);

  assign cfg_ok = (kernel_len != '0) && (stride != '0) &&
                  (CW'(kernel_len) <= CW'(act_len)) &&
                  (CW'(kernel_len) <= CW'(MAX_KERNEL)) &&
                  (CW'(act_len) <= CW'(MAX_ACT));

  assign last_k   = (kcnt == cfg.k - KW'(1));
  // Last window when the next one would run past the end of the activations.
  assign last_out = (BW'(base) + BW'(cfg.s) + BW'(cfg.k)) > BW'(cfg.a);

  // MAC datapath and output shaping (shift, ReLU, saturate).
  always_comb begin
    a_addr   = AIW'(base) + AIW'(kcnt);
    w_rd     = w_mem[KIW'(kcnt)];
    a_rd     = a_mem[a_addr];
    prod     = w_rd * a_rd;
    prod_ext = prod;
    acc_sum  = acc + prod_ext;
    acc_sh   = acc_sum >>> FRAC_BITS;
    if (cfg.relu && acc_sh[ACC_WIDTH-1])
      res = '0;
    else if (acc_sh > SAT_MAX)
      res = SAT_MAX[DATA_WIDTH-1:0];
    else if (acc_sh < SAT_MIN)
      res = SAT_MIN[DATA_WIDTH-1:0];
    else
      res = acc_sh[DATA_WIDTH-1:0];
  end

  // Storage: no reset. Weight wins when both enables are high.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      if (load_enable_weight) begin
        if (wptr < KW'(MAX_KERNEL)) w_mem[KIW'(wptr)] <= filter_input;
      end else if (load_enable_activation) begin
        if (aptr < AW'(MAX_ACT)) a_mem[AIW'(aptr)] <= activation_input;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && cfg_ok) state_nxt = MAC;
      MAC:     if (last_k) state_nxt = OUTPUT;
      OUTPUT:  if (hs) state_nxt = last_out ? DONE : MAC;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cfg                   <= '0;
      wptr                  <= '0;
      aptr                  <= '0;
      kcnt                  <= '0;
      base                  <= '0;
      acc                   <= '0;
      processingelement_out <= '0;
      out_valid             <= 1'b0;
      load_done             <= 1'b0;
      compute_done          <= 1'b0;
      cfg_error             <= 1'b0;
    end else begin
      load_done    <= 1'b0;
      compute_done <= 1'b0;
      cfg_error    <= 1'b0;
      case (state)
        IDLE: begin
          if (load_enable_weight) begin
            if (wptr_nx >= {1'b0, kernel_len}) begin
              wptr      <= '0;
              load_done <= 1'b1;
            end else begin
              wptr <= wptr_nx[KW-1:0];
            end
          end else if (load_enable_activation) begin
            if (aptr_nx >= {1'b0, act_len}) begin
              aptr      <= '0;
              load_done <= 1'b1;
            end else begin
              aptr <= aptr_nx[AW-1:0];
            end
          end
          // An accepted start overrides any pointer update from the same cycle.
          if (start) begin
            if (!cfg_ok) begin
              cfg_error <= 1'b1;
            end else begin
              cfg  <= '{k: kernel_len, a: act_len, s: stride, relu: relu_en};
              wptr <= '0;
              aptr <= '0;
              kcnt <= '0;
              base <= '0;
              acc  <= '0;
            end
          end
        end
        MAC: begin
          acc  <= acc_sum;
          kcnt <= kcnt + KW'(1);
          // Result is registered on the final tap so out_valid is up on OUTPUT entry.
          if (last_k) begin
            processingelement_out <= res;
            out_valid             <= 1'b1;
          end
        end
        OUTPUT: begin
          if (hs) begin
            out_valid <= 1'b0;
            if (last_out) begin
              compute_done <= 1'b1;
            end else begin
              base <= base + AW'(cfg.s);
              kcnt <= '0;
              acc  <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_conv1d.sv
// Directed bench for pe_conv1d with FRAC_BITS=0 so outputs are plain integer sums.
module tb_pe_conv1d;
  localparam int DW = 16;
  localparam int KW = 4;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] filter_input, activation_input;
  logic          load_enable_weight, load_enable_activation;
  logic [KW-1:0] kernel_len;
  logic [AW-1:0] act_len;
  logic [2:0]    stride;
  logic          relu_en, start, out_ready;
  logic [DW-1:0] processingelement_out;
  logic          out_valid, busy, load_done, compute_done, cfg_error;

  int n_cmp  = 0;
  int n_fail = 0;
  int wbuf [8];
  int abuf [64];

  always #5 clk = ~clk;

  pe_conv1d #(.DATA_WIDTH(16), .ACC_WIDTH(40), .MAX_KERNEL(8), .MAX_ACT(64), .FRAC_BITS(0)) dut (
    .clk(clk), .reset(reset),
    .filter_input(filter_input), .activation_input(activation_input),
    .load_enable_weight(load_enable_weight), .load_enable_activation(load_enable_activation),
    .kernel_len(kernel_len), .act_len(act_len), .stride(stride), .relu_en(relu_en),
    .start(start), .out_ready(out_ready),
    .processingelement_out(processingelement_out), .out_valid(out_valid), .busy(busy),
    .load_done(load_done), .compute_done(compute_done), .cfg_error(cfg_error)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Weight loads also raise the activation enable with junk to exercise priority.
  task automatic load_words(input bit is_w, input int n, output bit ld_early, output bit ld_last);
    ld_early = 0;
    ld_last  = 0;
    for (int i = 0; i < n; i++) begin
      if (is_w) begin
        filter_input           = 16'(wbuf[i]);
        activation_input       = 16'd99;
        load_enable_weight     = 1'b1;
        load_enable_activation = 1'b1;
      end else begin
        activation_input       = 16'(abuf[i]);
        load_enable_activation = 1'b1;
      end
      tick;
      if (load_done === 1'b1) begin
        if (i == n - 1) ld_last = 1;
        else            ld_early = 1;
      end
    end
    load_enable_weight     = 1'b0;
    load_enable_activation = 1'b0;
  endtask

  // Collects up to three outputs until compute_done; latency counted in clock
  // edges from the start edge (inclusive).
  task automatic run_conv(input bit do_start, input int k, input int a, input int s, input bit relu,
                          output int n, output logic [DW-1:0] v0, output logic [DW-1:0] v1,
                          output logic [DW-1:0] v2, output int lat1, output int gap, output bit to);
    int  t    = 0;
    int  last = -1;
    bit  done = 0;
    n = 0; v0 = 'x; v1 = 'x; v2 = 'x; lat1 = -1; gap = -1; to = 0;
    if (do_start) begin
      kernel_len = KW'(k);
      act_len    = AW'(a);
      stride     = 3'(s);
      relu_en    = relu;
      out_ready  = 1'b1;
      start      = 1'b1;
      tick;
      start = 1'b0;
      t = 1;
    end
    while (!done && t < 300) begin
      if (out_valid === 1'b1) begin
        if (n == 0) begin v0 = processingelement_out; lat1 = t; end
        else if (n == 1) begin v1 = processingelement_out; gap = t - last; end
        else if (n == 2) v2 = processingelement_out;
        last = t;
        n++;
      end
      if (compute_done === 1'b1) done = 1;
      else begin tick; t++; end
    end
    to = !done;
    if (done) tick;
  endtask

  task automatic load_basic;
    bit e, l;
    kernel_len = 4'd3;
    act_len    = 7'd5;
    wbuf[0] = 1; wbuf[1] = 2; wbuf[2] = 3;
    for (int i = 0; i < 5; i++) abuf[i] = i + 1;
    load_words(1, 3, e, l);
    load_words(0, 5, e, l);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    filter_input = '0; activation_input = '0;
    load_enable_weight = 0; load_enable_activation = 0;
    kernel_len = '0; act_len = '0; stride = '0; relu_en = 0; start = 0; out_ready = 1;
    tick; tick;
    n_cmp++;
    if ({out_valid, busy, load_done, compute_done, cfg_error} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 00000", {out_valid, busy, load_done, compute_done, cfg_error});
    end
    n_cmp++;
    if (processingelement_out !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_out: got %0d want 0", processingelement_out);
    end
    reset = 1'b1;
    tick;
  endtask

  task automatic test_load;
    bit e, l;
    kernel_len = 4'd3;
    act_len    = 7'd5;
    wbuf[0] = 1; wbuf[1] = 2; wbuf[2] = 3;
    for (int i = 0; i < 5; i++) abuf[i] = i + 1;
    load_words(1, 3, e, l);
    n_cmp++;
    if (e !== 1'b0 || l !== 1'b1) begin
      n_fail++;
      $display("FAIL load_done_weights: got early=%0b last=%0b want early=0 last=1", e, l);
    end
    tick;
    n_cmp++;
    if (load_done !== 1'b0) begin
      n_fail++;
      $display("FAIL load_done_pulse: got %b want 0", load_done);
    end
    load_words(0, 5, e, l);
    n_cmp++;
    if (e !== 1'b0 || l !== 1'b1) begin
      n_fail++;
      $display("FAIL load_done_acts: got early=%0b last=%0b want early=0 last=1", e, l);
    end
  endtask

  task automatic test_basic;
    int n, lat, gap; bit to; logic [DW-1:0] v0, v1, v2;
    run_conv(1, 3, 5, 1, 0, n, v0, v1, v2, lat, gap, to);
    n_cmp++;
    if (to || n != 3 || v0 !== 16'd14 || v1 !== 16'd20 || v2 !== 16'd26) begin
      n_fail++;
      $display("FAIL basic_values: got to=%0b n=%0d %0d,%0d,%0d want n=3 14,20,26", to, n, v0, v1, v2);
    end
    n_cmp++;
    if (lat != 4 || gap != 4) begin
      n_fail++;
      $display("FAIL basic_latency: got first=%0d gap=%0d want 4 4", lat, gap);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_stride;
    int n, lat, gap; bit to; logic [DW-1:0] v0, v1, v2;
    run_conv(1, 3, 5, 2, 0, n, v0, v1, v2, lat, gap, to);
    n_cmp++;
    if (to || n != 2 || v0 !== 16'd14 || v1 !== 16'd26) begin
      n_fail++;
      $display("FAIL stride_values: got to=%0b n=%0d %0d,%0d want n=2 14,26", to, n, v0, v1);
    end
  endtask

  task automatic test_relu_sat;
    int n, lat, gap; bit to, e, l; logic [DW-1:0] v0, v1, v2;
    kernel_len = 4'd1;
    act_len    = 7'd1;
    wbuf[0] = -1; load_words(1, 1, e, l);
    abuf[0] = 5;  load_words(0, 1, e, l);
    run_conv(1, 1, 1, 1, 1, n, v0, v1, v2, lat, gap, to);
    n_cmp++;
    if (to || n != 1 || v0 !== 16'd0 || lat != 2) begin
      n_fail++;
      $display("FAIL relu_clamp: got to=%0b n=%0d v=%0d lat=%0d want n=1 v=0 lat=2", to, n, v0, lat);
    end
    run_conv(1, 1, 1, 1, 0, n, v0, v1, v2, lat, gap, to);
    n_cmp++;
    if (to || n != 1 || v0 !== 16'hFFFB) begin
      n_fail++;
      $display("FAIL relu_off: got to=%0b n=%0d v=%h want n=1 v=fffb", to, n, v0);
    end
    wbuf[0] = 32767; load_words(1, 1, e, l);
    abuf[0] = 32767; load_words(0, 1, e, l);
    run_conv(1, 1, 1, 1, 0, n, v0, v1, v2, lat, gap, to);
    n_cmp++;
    if (to || n != 1 || v0 !== 16'h7FFF) begin
      n_fail++;
      $display("FAIL sat_pos: got to=%0b n=%0d v=%h want n=1 v=7fff", to, n, v0);
    end
    abuf[0] = -32768; load_words(0, 1, e, l);
    run_conv(1, 1, 1, 1, 0, n, v0, v1, v2, lat, gap, to);
    n_cmp++;
    if (to || n != 1 || v0 !== 16'h8000) begin
      n_fail++;
      $display("FAIL sat_neg: got to=%0b n=%0d v=%h want n=1 v=8000", to, n, v0);
    end
  endtask

  task automatic test_backpressure;
    int n, lat, gap, t, bad; bit to; logic [DW-1:0] v0, v1, v2;
    load_basic;
    kernel_len = 4'd3; act_len = 7'd5; stride = 3'd1; relu_en = 0;
    out_ready = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    t = 1;
    while (out_valid !== 1'b1 && t < 20) begin tick; t++; end
    n_cmp++;
    if (t != 4) begin
      n_fail++;
      $display("FAIL bp_first_valid: got %0d cycles want 4", t);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      filter_input = 16'd77;
      load_enable_weight = 1'b1;
      tick;
      if (!(out_valid === 1'b1 && processingelement_out === 16'd14 && busy === 1'b1 &&
            dut.acc === 40'sd14))
        bad++;
    end
    load_enable_weight = 1'b0;
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
    end
    out_ready = 1'b1;
    run_conv(0, 3, 5, 1, 0, n, v0, v1, v2, lat, gap, to);
    n_cmp++;
    if (to || n != 3 || v0 !== 16'd14 || v1 !== 16'd20 || v2 !== 16'd26 || gap != 4) begin
      n_fail++;
      $display("FAIL bp_drain: got to=%0b n=%0d %0d,%0d,%0d gap=%0d want n=3 14,20,26 gap=4",
               to, n, v0, v1, v2, gap);
    end
  endtask

  task automatic test_reject;
    kernel_len = 4'd4; act_len = 7'd3; stride = 3'd1;
    start = 1'b1;
    tick;
    start = 1'b0;
    n_cmp++;
    if (cfg_error !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reject_k_gt_a: got cfg_error=%b busy=%b want 1 0", cfg_error, busy);
    end
    tick;
    n_cmp++;
    if (cfg_error !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reject_pulse: got cfg_error=%b busy=%b want 0 0", cfg_error, busy);
    end
    kernel_len = 4'd3; act_len = 7'd5; stride = 3'd0;
    start = 1'b1;
    tick;
    start = 1'b0;
    n_cmp++;
    if (cfg_error !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reject_s0: got cfg_error=%b busy=%b want 1 0", cfg_error, busy);
    end
    tick;
  endtask

  task automatic test_reset_mid_mac;
    int n, lat, gap; bit to; logic [DW-1:0] v0, v1, v2;
    kernel_len = 4'd3; act_len = 7'd5; stride = 3'd1; relu_en = 0; out_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midmac_busy: got %b want 1", busy);
    end
    reset = 1'b0;
    tick;
    n_cmp++;
    if ({out_valid, busy, load_done, compute_done, cfg_error} !== 5'b0 ||
        processingelement_out !== 16'd0 || dut.acc !== 40'sd0) begin
      n_fail++;
      $display("FAIL midmac_reset: got flags=%b out=%0d want flags=00000 out=0",
               {out_valid, busy, load_done, compute_done, cfg_error}, processingelement_out);
    end
    reset = 1'b1;
    tick;
    run_conv(1, 3, 5, 1, 0, n, v0, v1, v2, lat, gap, to);
    n_cmp++;
    if (to || n != 3 || v0 !== 16'd14 || v1 !== 16'd20 || v2 !== 16'd26 || lat != 4) begin
      n_fail++;
      $display("FAIL rerun: got to=%0b n=%0d %0d,%0d,%0d lat=%0d want n=3 14,20,26 lat=4",
               to, n, v0, v1, v2, lat);
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_basic;
    test_stride;
    test_relu_sat;
    test_backpressure;
    test_reject;
    test_reset_mid_mac;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/pe_conv1d.md
PE_CONV1D -- requirements
Module: pe_conv1d

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- DATA_WIDTH, 16, signed sample/weight width.
- ACC_WIDTH, 40, accumulator width, at least 2*DATA_WIDTH.
- MAX_KERNEL, 8, weight storage depth.
- MAX_ACT, 64, activation storage depth.
- FRAC_BITS, 8, fixed-point fraction bits removed at output.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, synchronous, active-low reset.
- filter_input, in, DATA_WIDTH, weight load word.
- activation_input, in, DATA_WIDTH, activation load word.
- load_enable_weight, in, 1, filter_input valid this cycle.
- load_enable_activation, in, 1, activation_input valid this cycle.
- kernel_len, in, $clog2(MAX_KERNEL+1), K, sampled at start.
- act_len, in, $clog2(MAX_ACT+1), A, sampled at start and during loads.
- stride, in, 3, S, sampled at start.
- relu_en, in, 1, clamp negatives, sampled at start.
- start, in, 1, begin convolution.
- out_ready, in, 1, consumer accepts out_data.
- processingelement_out, out, DATA_WIDTH, result word.
- out_valid, out, 1, processingelement_out valid.
- busy, out, 1, high outside IDLE.
- load_done, out, 1, one-cycle pulse when a weight or activation block completes.
- compute_done, out, 1, one-cycle pulse when the last output is accepted.
- cfg_error, out, 1, one-cycle pulse when start is rejected.

Function
REQ-003 States SHALL be IDLE, MAC, OUTPUT, DONE.
REQ-004 Weight and activation loading SHALL occur only in IDLE.
- Each enabled cycle writes one word at the current pointer, then increments that pointer.
REQ-005 When a pointer reaches K (weights) or A (activations), that pointer SHALL wrap to 0 and load_done SHALL pulse the next cycle.
REQ-006 If both load enables are high in the same cycle, the weight word SHALL be written and the activation word discarded.
REQ-007 Load enables outside IDLE SHALL be ignored, with no pointer change.
REQ-008 start in IDLE SHALL be rejected if any of the following hold: K==0, S==0, K>A, K>MAX_KERNEL, A>MAX_ACT.
- On rejection: cfg_error pulses the next cycle and the state stays IDLE.
REQ-009 An accepted start SHALL latch K, A, S and relu_en, clear both load pointers, set the output index o=0, clear acc, and enter MAC.
REQ-010 In MAC, each cycle SHALL perform acc += sext(w[k]*a[o*S+k]) for k=0..K-1.
- The product is full-width signed; acc wraps modulo 2^ACC_WIDTH.
- After K cycles the state goes to OUTPUT.
REQ-011 On entering OUTPUT, the result SHALL be computed as acc>>>FRAC_BITS (arithmetic shift), saturated to the signed DATA_WIDTH range.
- If relu_en is set, negative results become 0.
- The result is registered onto processingelement_out with out_valid=1.
REQ-012 processingelement_out and out_valid SHALL hold stable until a cycle with out_valid && out_ready; there is no combinational ready-to-valid path.
REQ-013 Output latency SHALL be: out_valid rises K+1 cycles after the start cycle, and K+1 cycles after each handshake for later outputs.
REQ-014 The number of outputs SHALL be N = floor((A-K)/S)+1.
REQ-015 On a handshake, the block SHALL behave as follows.
- If o<N-1: increment o, clear acc, enter MAC.
- Otherwise: enter DONE.
REQ-016 DONE SHALL last one cycle, pulse compute_done, and return to IDLE.
REQ-017 start asserted outside IDLE SHALL be ignored.
REQ-018 Storage contents SHALL persist across runs, so repeated starts without reloading reuse the stored weights and activations.

Reset
REQ-019 reset low at a rising edge SHALL force the following, from any state including mid-MAC or mid-OUTPUT:
- state=IDLE.
- Both pointers, o and acc = 0.
- processingelement_out=0.
- out_valid, busy, load_done, compute_done and cfg_error all 0.
REQ-020 Storage arrays SHALL NOT require reset.

Verification
REQ-021 Bench (FRAC_BITS=0) SHALL cover:
- Basic convolution: load w=1,2,3 and a=1,2,3,4,5, then start with K=3, A=5, S=1, out_ready=1 -> outputs 14, 20, 26; first out_valid 4 cycles after start; compute_done after the third output.
- Stride: same data with S=2 -> outputs 14, 26 only.
- ReLU and saturation: w=-1 and a=5 with K=1, A=1, relu_en=1 -> output 0. With relu_en=0, w=a=32767 and DATA_WIDTH=16 -> output 32767.
- Backpressure: out_ready=0 for 10 cycles on the first output -> value and out_valid held constant, and no further MAC occurs.
- Rejection and reset: start with K=4, A=3 -> cfg_error pulse, busy stays 0. reset low mid-MAC -> all outputs 0 and IDLE next cycle; a rerun without reloading gives the same results.
